magni_to_compl_serial: RTL and testbench
========================================

# magni_to_compl_serial

Bit-serial converter from 6-bit sign-magnitude to 6-bit two's complement. It is the inverse of the existing complement-to-magnitude path. Input is the sign-magnitude value produced by the display/arithmetic front end; output feeds the two's-complement adder datapath. A single-bit negate cell is reused across 5 shift cycles, with valid/ready handshakes on both sides.

## Interface
- Parameters: none. Width is fixed by package constant `MAGNI_W` = 6.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous reset, active high.
- `in_valid`  input  1  `magni_in` holds a value to convert.
- `in_ready`  output  1  high only in IDLE.
- `magni_in`  input  6  bit5 = sign, bits4:0 = magnitude.
- `out_valid`  output  1  `compl_out` is valid; high only in DONE.
- `out_ready`  input  1  downstream accepts `compl_out`.
- `compl_out`  output  6  two's-complement result; held stable while `out_valid` is high.
- `neg_zero`  output  1  present only with `MAGNI_NEGZERO_FLAG_EN`.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: capture `magni_in[4:0]` into shift register `mag_sr` and the sign into `sgn`. Clear the result register, `seen_one`=0, `bit_cnt`=0. Go to SHIFT.
- SHIFT, one magnitude bit per cycle, LSB first:
  - Let b = `mag_sr[0]`.
  - If `sgn`=0: out bit = b.
  - If `sgn`=1: out bit = b XOR `seen_one`.
  - Then `seen_one` |= b.
  - Out bit shifts into the result from the MSB side of bits4:0; `mag_sr` shifts right.
  - After `bit_cnt`=4, go to DONE.
- Sign bit: on entry to DONE, `compl_out[5]` = `sgn` AND `seen_one`.
- DONE: `out_valid`=1. On `out_ready`, go to IDLE. No input is accepted in DONE, even when `out_ready` is high.
- Arithmetic range:
  - Inputs span −31..+31, all representable; no overflow is possible.
  - Negative zero (100000) yields 000000.
  - Positive inputs take the same fixed latency.
- Reset values: state=IDLE, `in_ready`=1 from the first cycle after reset, `out_valid`=0, `compl_out`=000000, `neg_zero`=0, internal registers 0.
- Reset mid-operation (SHIFT or DONE): abort and discard the conversion. Return to IDLE with the values above; no `out_valid` pulse.
- `in_valid` while not in IDLE is ignored; `magni_in` is sampled only at the accept edge.

## Timing
- Accept at edge N (IDLE, `in_valid`=1).
- SHIFT processes bits 0..4 at edges N+1..N+5.
- `out_valid` rises after edge N+5: latency 5 cycles from accept.
- Minimum turnaround is 7 cycles per conversion (accept, 5 shift, 1 DONE with `out_ready`=1), then IDLE again.
- `out_ready` low holds DONE indefinitely with `compl_out` unchanged.
- All outputs are registered except `in_ready`/`out_valid`, which decode the state register.

## Configuration
- `MAGNI_NEGZERO_FLAG_EN`
  - Defined:
    - `neg_zero` port exists.
    - Set at entry to DONE when `sgn`=1 and `seen_one`=0; valid alongside `out_valid`.
    - Cleared on leaving DONE or on reset.
  - Undefined: the port and its logic are absent; conversion behaviour is identical.

## Structure
- Shared package `magni_pkg`:
  - `MAGNI_W`=6.
  - `MAG_BITS`=5.
  - State enum `conv_state_t` {IDLE, SHIFT, DONE}.
  - The package is also imported by the complement-to-magnitude block.
- Sub-module `serial_negate_cell`:
  - Inputs: `clk`, `rst`, `clr`, `en`, `neg`, `bit_in`.
  - Output: `bit_out`.
  - Holds the `seen_one` flop; implements copy-through-first-one-then-invert.
  - Top level owns the FSM, counter and shift registers.

## Test plan
- +13 (001101) with `out_ready`=1 → `out_valid` 5 cycles after accept, `compl_out`=001101.
- −13 (101101) → 110011; −1 (100001) → 111111; −31 (111111) → 100001.
- Negative zero (100000) → `compl_out`=000000; `neg_zero`=1 with the macro defined, port absent without it.
- Backpressure: −5 (100101), `out_ready` low for 3 cycles → `compl_out`=111011 held stable, `in_ready`=0 throughout, and `in_valid` pulses ignored.
- `rst` asserted at the 3rd SHIFT cycle → next cycle IDLE, `out_valid`=0, `compl_out`=000000. A following −2 (100010) converts to 111110.
- Back-to-back stream of all 64 inputs with random `out_ready` → every result matches the reference model and no result is dropped or duplicated.

Source files
------------

// File: rtl/magni_pkg.sv
`default_nettype none
// ============================================================================
// Module  : magni_pkg
// Purpose : Shared constants and state encoding for the sign-magnitude /
//           two's-complement serial conversion blocks. The
//           complement-to-magnitude path imports it as well.
// Contents: MAGNI_W   - full word width (sign + magnitude)
//           MAG_BITS  - magnitude width, also the number of shift cycles
//           CNT_W     - width of the shift-cycle counter
//           LAST_CNT  - counter value of the final shift cycle
//           conv_state_t - IDLE / SHIFT / DONE
// Revision: 1.0 - initial release
// ============================================================================
package magni_pkg;

    localparam int MAGNI_W  = 6;
    localparam int MAG_BITS = MAGNI_W - 1;
    localparam int CNT_W    = 3;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAG_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

endpackage : magni_pkg
`default_nettype wire

// File: rtl/serial_negate_cell.sv
`default_nettype none
// ============================================================================
// Module  : serial_negate_cell
// Purpose : One-bit serial two's-complement negation cell. Bits arrive LSB
//           first. While negating, bits are copied through up to and
//           including the first '1'; every later bit is inverted.
// Ports   : clk     - rising-edge clock
//           rst     - synchronous active-high reset
//           clr     - start of a new word, clears the seen-one flag
//           en      - a bit is being processed this cycle
//           neg     - 1 = negate the stream, 0 = pass through
//           bit_in  - current input bit
//           bit_out - current output bit (combinational from bit_in)
// Revision: 1.0 - initial release
// ============================================================================
module serial_negate_cell (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic neg,
    input  logic bit_in,
    output logic bit_out
);

    logic seen_one_q;
    logic seen_one_d;

    always_comb begin
        seen_one_d = seen_one_q;
        if (clr) begin
            seen_one_d = 1'b0;
        end else if (en) begin
            seen_one_d = seen_one_q | bit_in;
        end
        // The first '1' itself passes unchanged because the flag only
        // updates after this bit has been produced.
        bit_out = neg ? (bit_in ^ seen_one_q) : bit_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_one_q <= 1'b0;
        end else begin
            seen_one_q <= seen_one_d;
        end
    end

endmodule : serial_negate_cell
`default_nettype wire

// File: rtl/magni_to_compl_serial.sv
`default_nettype none
// ============================================================================
// Module  : magni_to_compl_serial
// Purpose : Bit-serial converter from 6-bit sign-magnitude to 6-bit two's
//           complement. Magnitude bits are fed LSB first through a single
//           serial_negate_cell over five SHIFT cycles. Valid/ready
//           handshakes on input and output.
// Ports   : clk        - rising-edge clock
//           rst        - synchronous active-high reset
//           in_valid   - magni_in holds a value to convert
//           in_ready   - high only in IDLE
//           magni_in   - bit5 sign, bits4:0 magnitude
//           out_valid  - compl_out valid, high only in DONE
//           out_ready  - downstream accepts compl_out
//           compl_out  - registered two's-complement result
//           neg_zero   - negative-zero flag (only with MAGNI_NEGZERO_FLAG_EN)
// Options : MAGNI_NEGZERO_FLAG_EN - adds the neg_zero output and its flop
// Revision: 1.0 - initial release
// ============================================================================
module magni_to_compl_serial
    import magni_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAGNI_W-1:0] magni_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAGNI_W-1:0] compl_out
`ifdef MAGNI_NEGZERO_FLAG_EN
    ,
    output logic               neg_zero
`endif
);

    conv_state_t         state_q;
    logic [MAG_BITS-1:0] mag_sr_q;
    logic                sgn_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [MAGNI_W-1:0]  res_q;

    logic                w_accept;
    logic                w_shift_en;
    logic                w_last;
    logic                w_out_bit;
    logic [MAG_BITS-1:0] res_mag_d;
    logic                w_mag_nz;

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign compl_out  = res_q;

    assign w_accept   = (state_q == IDLE) && in_valid;
    assign w_shift_en = (state_q == SHIFT);
    assign w_last     = (bit_cnt_q == LAST_CNT);

    serial_negate_cell u_negate (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_accept),
        .en      (w_shift_en),
        .neg     (sgn_q),
        .bit_in  (mag_sr_q[0]),
        .bit_out (w_out_bit)
    );

    // Result bits enter from the top of the magnitude field so that after
    // five shifts the first (LSB) output bit sits at bit 0.
    always_comb begin
        res_mag_d = {w_out_bit, res_q[MAG_BITS-1:1]};
        // Serial negation of a magnitude is nonzero exactly when the
        // magnitude had a '1' somewhere, so on the final shift this OR is
        // the cell's updated seen-one state.
        w_mag_nz  = |res_mag_d;
    end

`ifdef MAGNI_NEGZERO_FLAG_EN
    logic neg_zero_q;
    assign neg_zero = neg_zero_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mag_sr_q   <= '0;
            sgn_q      <= 1'b0;
            bit_cnt_q  <= '0;
            res_q      <= '0;
`ifdef MAGNI_NEGZERO_FLAG_EN
            neg_zero_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mag_sr_q  <= magni_in[MAG_BITS-1:0];
                        sgn_q     <= magni_in[MAGNI_W-1];
                        res_q     <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= SHIFT;
                    end
                end

                SHIFT: begin
                    res_q[MAG_BITS-1:0] <= res_mag_d;
                    mag_sr_q            <= mag_sr_q >> 1;
                    bit_cnt_q           <= bit_cnt_q + CNT_W'(1);
                    if (w_last) begin
                        // Negative zero keeps a clear sign bit.
                        res_q[MAGNI_W-1] <= sgn_q & w_mag_nz;
`ifdef MAGNI_NEGZERO_FLAG_EN
                        neg_zero_q       <= sgn_q & ~w_mag_nz;
`endif
                        state_q          <= DONE;
                    end
                end

                DONE: begin
                    // compl_out is held; nothing is accepted here.
                    if (out_ready) begin
`ifdef MAGNI_NEGZERO_FLAG_EN
                        neg_zero_q <= 1'b0;
`endif
                        state_q    <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule : magni_to_compl_serial
`default_nettype wire

// File: tb/tb_magni_to_compl_serial.sv
`default_nettype none
// ============================================================================
// Module  : tb_magni_to_compl_serial
// Purpose : Directed self-checking bench for magni_to_compl_serial:
//           reset state, signed conversions, negative zero, backpressure,
//           mid-conversion reset and a 64-value stream with random
//           out_ready against a small arithmetic reference.
// Options : MAGNI_NEGZERO_FLAG_EN - also checks the neg_zero output
// Revision: 1.0 - initial release
// ============================================================================
module tb_magni_to_compl_serial;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] magni_in;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] compl_out;
`ifdef MAGNI_NEGZERO_FLAG_EN
    logic       neg_zero;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    magni_to_compl_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .magni_in  (magni_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .compl_out (compl_out)
`ifdef MAGNI_NEGZERO_FLAG_EN
        ,
        .neg_zero  (neg_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: negate the magnitude as a 6-bit integer.
    function automatic logic [5:0] model_conv(input logic [5:0] m);
        logic [5:0] mag;
        mag = {1'b0, m[4:0]};
        return m[5] ? 6'(6'd0 - mag) : mag;
    endfunction

    // One conversion starting from IDLE, at #1 after a clock edge.
    // hold = number of DONE cycles with out_ready low.
    task automatic convert(input string tag, input logic [5:0] m, input logic [5:0] exp,
                           input int hold, input logic exp_nz);
        int lat;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        magni_in  = m;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        magni_in  = ~m;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd5);
        chk({tag, "_value"}, 32'(compl_out), 32'(exp));
`ifdef MAGNI_NEGZERO_FLAG_EN
        chk({tag, "_neg_zero"}, 32'(neg_zero), 32'(exp_nz));
`else
        if (exp_nz) begin
            chk({tag, "_value_nz"}, 32'(compl_out), 32'd0);
        end
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid;
            magni_in = 6'(i * 7 + 3);
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
            chk({tag, "_hold_value"}, 32'(compl_out), 32'(exp));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_exit_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_exit_ready"}, 32'(in_ready), 32'd1);
`ifdef MAGNI_NEGZERO_FLAG_EN
        chk({tag, "_exit_nz"}, 32'(neg_zero), 32'd0);
`endif
    endtask

    initial begin
        logic [5:0] q[$];
        logic [5:0] obs;
        logic [5:0] exp;
        int         next_in;
        int         got;
        int         cycles;
        int         seen_valid;
        logic       acc;
        logic       dn;

        rst       = 1'b1;
        in_valid  = 1'b0;
        magni_in  = 6'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_compl",     32'(compl_out), 32'd0);
`ifdef MAGNI_NEGZERO_FLAG_EN
        chk("reset_neg_zero",  32'(neg_zero),  32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        convert("pos13",  6'b001101, 6'b001101, 0, 1'b0);
        convert("neg13",  6'b101101, 6'b110011, 0, 1'b0);
        convert("neg1",   6'b100001, 6'b111111, 0, 1'b0);
        convert("neg31",  6'b111111, 6'b100001, 0, 1'b0);
        convert("pos31",  6'b011111, 6'b011111, 0, 1'b0);
        convert("pos0",   6'b000000, 6'b000000, 0, 1'b0);
        convert("negzero",6'b100000, 6'b000000, 0, 1'b1);
        convert("bp_neg5",6'b100101, 6'b111011, 3, 1'b0);

        // Reset during the third SHIFT cycle.
        in_valid = 1'b1;
        magni_in = 6'b100101;
        @(posedge clk); #1;          // accept
        in_valid = 1'b0;
        @(posedge clk); #1;          // shift 0
        @(posedge clk); #1;          // shift 1
        rst = 1'b1;
        @(posedge clk); #1;          // reset replaces shift 2
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_compl",     32'(compl_out), 32'd0);
        rst = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid++;
        end
        chk("midrst_no_pulse", 32'(seen_valid), 32'd0);
        convert("neg2", 6'b100010, 6'b111110, 0, 1'b0);

        // All 64 inputs back to back with random out_ready.
        next_in = 0;
        got     = 0;
        cycles  = 0;
        while (got < 64 && cycles < 3000) begin
            in_valid  = (next_in < 64);
            magni_in  = 6'(next_in);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = in_valid && in_ready;
            dn  = out_valid && out_ready;
            obs = compl_out;
            if (acc) begin
                q.push_back(model_conv(6'(next_in)));
                next_in++;
            end
            if (dn) begin
                chk("stream_pending", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    exp = q.pop_front();
                    chk("stream_value", 32'(obs), 32'(exp));
                end
                got++;
            end
            @(posedge clk); #1;
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_outputs", 32'(got), 32'd64);
        chk("stream_inputs",  32'(next_in), 32'd64);
        chk("stream_leftover", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_magni_to_compl_serial
`default_nettype wire
